// File: rtl/y86_dmem_ctrl_if.sv
// Request/response bundle between a Y86 execute stage and y86_dmem_ctrl.
// Ports: request side (req_valid/req_ready, icode, val_a, val_e, val_p, pc_invalid,
//   instr_invalid, num_valid_instr) and response side (resp_valid/resp_ready, val_m, flags).
interface y86_dmem_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        icode;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_e;
  logic [DATA_W-1:0] val_p;
  logic              pc_invalid;
  logic              instr_invalid;
  logic [DATA_W-1:0] num_valid_instr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] val_m;
  logic              imem_error;
  logic              dmem_error;
  logic              mem_status;

  // Execute stage side
  modport master (
    output req_valid, icode, val_a, val_e, val_p, pc_invalid, instr_invalid,
           num_valid_instr, resp_ready,
    input  req_ready, resp_valid, val_m, imem_error, dmem_error, mem_status
  );

  // Memory controller side
  modport slave (
    input  req_valid, icode, val_a, val_e, val_p, pc_invalid, instr_invalid,
           num_valid_instr, resp_ready,
    output req_ready, resp_valid, val_m, imem_error, dmem_error, mem_status
  );
endinterface

// File: rtl/y86_dmem_ctrl.sv
// Y86 data-memory stage: one handshaked request -> read/write of a word-addressed array -> response.
// Latency: resp_valid rises LATENCY edges after the accept edge; one transaction per LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE; response (val_m, flags) held stable until resp_ready is seen.
// Ports: clk, reset (async, active-high), bus (slave modport of y86_dmem_ctrl_if):
//   req_valid/req_ready, icode, val_a, val_e, val_p, pc_invalid, instr_invalid, num_valid_instr,
//   resp_valid/resp_ready, val_m, imem_error, dmem_error, mem_status.
module y86_dmem_ctrl #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 4096,
  parameter int LATENCY     = 2,
  parameter int INIT_OFFSET = 1
) (
  input  logic            clk,
  input  logic            reset,
  y86_dmem_ctrl_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LATENCY - 1);

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        icode_q, icode_d;
  logic [DATA_W-1:0] val_a_q, val_a_d;
  logic [DATA_W-1:0] val_e_q, val_e_d;
  logic [DATA_W-1:0] val_p_q, val_p_d;
  logic [DATA_W-1:0] nvi_q, nvi_d;
  logic              suppress_q, suppress_d;
  logic [DATA_W-1:0] val_m_q, val_m_d;
  logic              imem_err_q, imem_err_d;
  logic              dmem_err_q, dmem_err_d;
  logic              status_q, status_d;

  // The array holds each word as a delta from its time-zero image (i + INIT_OFFSET), so the
  // required initial contents fall out of an all-zero power-up image and need no load sequence.
  logic [DATA_W-1:0] store_q [DEPTH];

  logic              is_write, is_read, is_ret, addr_from_a, access, in_range, mem_we;
  logic [DATA_W-1:0] addr, wr_data, rd_data, store_wdata;
  logic [AW-1:0]     idx;

  // Decode of the captured request
  always_comb begin
    is_write    = (icode_q == I_RMMOVQ) || (icode_q == I_CALL) || (icode_q == I_PUSHQ);
    is_read     = (icode_q == I_MRMOVQ) || (icode_q == I_RET)  || (icode_q == I_POPQ);
    is_ret      = (icode_q == I_RET);
    addr_from_a = (icode_q == I_RET) || (icode_q == I_POPQ);
    access      = (is_write || is_read) && !suppress_q;
    addr        = addr_from_a ? val_a_q : val_e_q;
    in_range    = addr < DATA_W'(DEPTH);
    idx         = addr[AW-1:0];
    wr_data     = (icode_q == I_CALL) ? val_p_q : val_a_q;
    rd_data     = store_q[idx] + DATA_W'(idx) + DATA_W'(INIT_OFFSET);
    store_wdata = wr_data - DATA_W'(idx) - DATA_W'(INIT_OFFSET);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      icode_q    <= '0;
      val_a_q    <= '0;
      val_e_q    <= '0;
      val_p_q    <= '0;
      nvi_q      <= '0;
      suppress_q <= 1'b0;
      val_m_q    <= '0;
      imem_err_q <= 1'b0;
      dmem_err_q <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      icode_q    <= icode_d;
      val_a_q    <= val_a_d;
      val_e_q    <= val_e_d;
      val_p_q    <= val_p_d;
      nvi_q      <= nvi_d;
      suppress_q <= suppress_d;
      val_m_q    <= val_m_d;
      imem_err_q <= imem_err_d;
      dmem_err_q <= dmem_err_d;
      status_q   <= status_d;
    end
  end

  // Array is deliberately outside the reset domain; mem_we is gated by the reset-cleared
  // state, so a reset during ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      store_q[idx] <= store_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    icode_d    = icode_q;
    val_a_d    = val_a_q;
    val_e_d    = val_e_q;
    val_p_d    = val_p_q;
    nvi_d      = nvi_q;
    suppress_d = suppress_q;
    val_m_d    = val_m_q;
    imem_err_d = imem_err_q;
    dmem_err_d = dmem_err_q;
    status_d   = status_q;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          icode_d    = bus.icode;
          val_a_d    = bus.val_a;
          val_e_d    = bus.val_e;
          val_p_d    = bus.val_p;
          nvi_d      = bus.num_valid_instr;
          suppress_d = bus.pc_invalid || bus.instr_invalid;
          cnt_d      = '0;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          // Commit edge: memory write and response registers update together
          state_d    = S_RESP;
          imem_err_d = 1'b0;
          dmem_err_d = 1'b0;
          status_d   = 1'b0;
          if (access) begin
            if (!in_range) begin
              imem_err_d = 1'b1;
              // An unreachable return target can never be a valid instruction index
              dmem_err_d = is_ret;
            end else begin
              if (is_write) begin
                mem_we   = 1'b1;
                status_d = 1'b1;
              end
              if (is_read) begin
                val_m_d  = rd_data;
                status_d = 1'b1;
              end
              if (is_ret && (rd_data > nvi_q)) begin
                dmem_err_d = 1'b1;
                status_d   = 1'b0;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.val_m      = val_m_q;
  assign bus.imem_error = imem_err_q;
  assign bus.dmem_error = dmem_err_q;
  assign bus.mem_status = status_q;

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// Directed bench for y86_dmem_ctrl: a word-array model of the data memory predicts val_m and
// flags for every accepted request; a negedge compare process checks each response cycle, and
// the driver pins latency, backpressure, reset behaviour and a few hand-computed literals.
module tb_y86_dmem_ctrl;
  localparam int DATA_W      = 64;
  localparam int DEPTH       = 4096;
  localparam int LATENCY     = 2;
  localparam int INIT_OFFSET = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  y86_dmem_ctrl_if #(.DATA_W(DATA_W)) bus();

  y86_dmem_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_OFFSET(INIT_OFFSET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state
  logic [63:0] mmem [DEPTH];
  logic [63:0] e_valm;
  logic        e_imem, e_dmem, e_st;

  // Outputs sampled on the first response cycle of the last transaction
  logic [63:0] r_valm;
  logic        r_imem, r_dmem, r_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-stage rules applied directly to the word array
  task automatic model_apply(input logic [3:0] ic, input logic [63:0] a, e, p, nvi,
                             input bit pci, ii);
    e_imem = 1'b0;
    e_dmem = 1'b0;
    e_st   = 1'b0;
    if (pci || ii) return;
    case (ic)
      4'd4, 4'd10: begin
        if (e >= DEPTH) e_imem = 1'b1;
        else begin mmem[e[11:0]] = a; e_st = 1'b1; end
      end
      4'd8: begin
        if (e >= DEPTH) e_imem = 1'b1;
        else begin mmem[e[11:0]] = p; e_st = 1'b1; end
      end
      4'd5: begin
        if (e >= DEPTH) e_imem = 1'b1;
        else begin e_valm = mmem[e[11:0]]; e_st = 1'b1; end
      end
      4'd11: begin
        if (a >= DEPTH) e_imem = 1'b1;
        else begin e_valm = mmem[a[11:0]]; e_st = 1'b1; end
      end
      4'd9: begin
        if (a >= DEPTH) begin e_imem = 1'b1; e_dmem = 1'b1; end
        else begin
          e_valm = mmem[a[11:0]];
          if (e_valm > nvi) e_dmem = 1'b1;
          else e_st = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // Every response cycle must match the model
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.resp_valid === 1'b1) begin
      check("cmp_val_m", bus.val_m, e_valm);
      check("cmp_imem_error", bus.imem_error, e_imem);
      check("cmp_dmem_error", bus.dmem_error, e_dmem);
      check("cmp_mem_status", bus.mem_status, e_st);
    end
  end

  task automatic do_txn(input logic [3:0] ic, input logic [63:0] a, e, p, nvi,
                        input bit pci, ii, input int hold, input bit poke);
    int  lat;
    bit  got;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.icode = ic; bus.val_a = a; bus.val_e = e; bus.val_p = p;
    bus.num_valid_instr = nvi; bus.pc_invalid = pci; bus.instr_invalid = ii;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // Change inputs after acceptance; the captured request must be used
    bus.icode = 4'd4; bus.val_e = 64'd7; bus.val_a = 64'hBAD; bus.val_p = 64'hBAD;
    bus.num_valid_instr = 64'd0; bus.pc_invalid = 1'b0; bus.instr_invalid = 1'b0;
    model_apply(ic, a, e, p, nvi, pci, ii);
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: no resp_valid within 20 cycles, expected %0d", LATENCY);
      return;
    end
    check("resp_latency", 64'(lat), 64'(LATENCY));
    r_valm = bus.val_m; r_imem = bus.imem_error; r_dmem = bus.dmem_error; r_st = bus.mem_status;
    for (int h = 0; h < hold; h++) begin
      check("hold_req_ready", bus.req_ready, 1'b0);
      check("hold_resp_valid", bus.resp_valid, 1'b1);
      check("hold_val_m", bus.val_m, r_valm);
      if (poke) begin
        bus.icode = 4'd4; bus.val_e = 64'd300; bus.val_a = 64'hDEAD;
        bus.req_valid = 1'b1;
      end
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 1'b0);
    check("back_idle", bus.req_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = 64'(i + INIT_OFFSET);
    e_valm = '0; e_imem = 1'b0; e_dmem = 1'b0; e_st = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0; bus.icode = '0;
    bus.val_a = '0; bus.val_e = '0; bus.val_p = '0; bus.num_valid_instr = '0;
    bus.pc_invalid = 1'b0; bus.instr_invalid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_val_m", bus.val_m, 64'd0);
    check("rst_flags", {bus.imem_error, bus.dmem_error, bus.mem_status}, 3'b000);
    reset = 1'b0;

    // Time-zero contents
    do_txn(4'd5, 64'd0, 64'd7, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_init_read", r_valm, 64'd8);
    check("lit_init_status", r_st, 1'b1);

    // Store then load a negative value
    do_txn(4'd10, -64'sd5, 64'd100, 64'd0, 64'd0, 0, 0, 0, 0);
    do_txn(4'd5, 64'd0, 64'd100, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_push_read", r_valm, 64'hFFFF_FFFF_FFFF_FFFB);

    // First out-of-range address; must not alias onto word 0
    do_txn(4'd4, 64'd9, 64'd4096, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_oob_imem", r_imem, 1'b1);
    check("lit_oob_status", r_st, 1'b0);
    do_txn(4'd5, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_no_alias", r_valm, 64'd1);

    // Last in-range word
    do_txn(4'd4, 64'h1234, 64'd4095, 64'd0, 64'd0, 0, 0, 0, 0);
    do_txn(4'd5, 64'd0, 64'd4095, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_top_word", r_valm, 64'h1234);

    // call / ret target check
    do_txn(4'd8, 64'd0, 64'd50, 64'd30, 64'd0, 0, 0, 0, 0);
    do_txn(4'd9, 64'd50, 64'd0, 64'd0, 64'd20, 0, 0, 0, 0);
    check("lit_ret_bad_valm", r_valm, 64'd30);
    check("lit_ret_bad_dmem", r_dmem, 1'b1);
    check("lit_ret_bad_status", r_st, 1'b0);
    do_txn(4'd9, 64'd50, 64'd0, 64'd0, 64'd40, 0, 0, 0, 0);
    check("lit_ret_ok_dmem", r_dmem, 1'b0);
    check("lit_ret_ok_status", r_st, 1'b1);
    do_txn(4'd9, 64'd50, 64'd0, 64'd0, 64'd30, 0, 0, 0, 0);
    check("lit_ret_equal_dmem", r_dmem, 1'b0);

    // Backpressure: response held 5 cycles while another request is offered
    do_txn(4'd11, 64'd50, 64'd0, 64'd0, 64'd0, 0, 0, 5, 1);
    check("lit_pop_read", r_valm, 64'd30);
    do_txn(4'd5, 64'd0, 64'd300, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_poke_ignored", r_valm, 64'd301);

    // Suppressed accesses and non-memory icodes
    do_txn(4'd4, 64'd99, 64'd10, 64'd0, 64'd0, 1, 0, 0, 0);
    check("lit_pcinv_status", r_st, 1'b0);
    do_txn(4'd5, 64'd0, 64'd10, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_pcinv_nowrite", r_valm, 64'd11);
    do_txn(4'd5, 64'd0, 64'd7, 64'd0, 64'd0, 0, 1, 0, 0);
    check("lit_instrinv_held", r_valm, 64'd11);
    do_txn(4'd6, 64'd0, 64'd3, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_opq_status", r_st, 1'b0);
    do_txn(4'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_huge_addr_imem", r_imem, 1'b1);

    // Reset during ACCESS of a push: no write, outputs cleared
    @(negedge clk);
    bus.icode = 4'd10; bus.val_e = 64'd200; bus.val_a = 64'd77;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    e_valm = '0; e_imem = 1'b0; e_dmem = 1'b0; e_st = 1'b0;
    check("midrst_resp_valid", bus.resp_valid, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b1);
    check("midrst_val_m", bus.val_m, 64'd0);
    check("midrst_flags", {bus.imem_error, bus.dmem_error, bus.mem_status}, 3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_txn(4'd5, 64'd0, 64'd200, 64'd0, 64'd0, 0, 0, 0, 0);
    check("lit_midrst_nowrite", r_valm, 64'd201);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
